// File: rtl/multisim_server_pull_multi.sv
// Multi-channel buffered pull server.
// Each channel owns a DEPTH-entry prefetch FIFO with a valid/ready head.
// A round-robin scheduler issues at most one server poll per clock.
// An exponential idle backoff throttles polling of channels whose server is empty.
// The server boundary is exposed as ports rather than DPI calls:
//   - server_name_set stands for "server name is non-empty".
//   - start_vld/start_ch replace the per-channel start call.
//   - poll_vld/poll_ch/poll_hit/poll_data replace the packed get-data call.
//     The response is same-cycle, like a function return.
module multisim_server_pull_multi #(
   parameter int NUM_CHANNELS       = 4,
   parameter int DATA_WIDTH         = 64,
   parameter int DEPTH              = 4,
   parameter int DELAY_ACTIVE       = 0,
   parameter int DELAY_INACTIVE_MIN = 1,
   parameter int DELAY_INACTIVE_MAX = 8,
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               server_name_set,
   output logic                               start_vld,
   output logic [CW-1:0]                      start_ch,
   output logic                               poll_vld,
   output logic [CW-1:0]                      poll_ch,
   input  logic                               poll_hit,
   input  logic [DATA_WIDTH-1:0]              poll_data,
   input  logic [NUM_CHANNELS-1:0]            data_rdy,
   output logic [NUM_CHANNELS-1:0]            data_vld,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
   output logic [NUM_CHANNELS*LW-1:0]         fill_level,
   output logic                               all_idle
);

   localparam int PW    = $clog2(DEPTH);
   localparam int MAXD0 = (DELAY_INACTIVE_MAX > DELAY_INACTIVE_MIN) ? DELAY_INACTIVE_MAX
                                                                    : DELAY_INACTIVE_MIN;
   localparam int MAXD  = (DELAY_ACTIVE > MAXD0) ? DELAY_ACTIVE : MAXD0;
   localparam int BW    = (MAXD < 1) ? 1 : $clog2(MAXD + 1);

   logic                    started_q, started_d;
   logic [CW-1:0]           start_idx_q, start_idx_d;
   logic [CW-1:0]           rr_q, rr_d;
   logic [NUM_CHANNELS-1:0] elig;
   logic [NUM_CHANNELS-1:0] pop;
   logic [NUM_CHANNELS-1:0] busy;

   // Start every channel's server once, in index order, once a name is present.
   always_comb begin
      start_vld   = server_name_set && !started_q;
      start_ch    = start_idx_q;
      start_idx_d = start_idx_q;
      started_d   = started_q;
      if (!server_name_set) begin
         start_idx_d = '0;
         started_d   = 1'b0;
      end else if (!started_q) begin
         if (start_idx_q == CW'(NUM_CHANNELS - 1)) begin
            start_idx_d = '0;
            started_d   = 1'b1;
         end else begin
            start_idx_d = start_idx_q + 1'b1;
         end
      end
   end

   // Start state deliberately ignores rst_n: a reset must not restart the servers.
   always_ff @(posedge clk) begin
      started_q   <= started_d;
      start_idx_q <= start_idx_d;
   end

   // Round-robin pick: the first eligible channel at or after rr_q, wrapping.
   always_comb begin
      int  idx;
      logic found;
      logic [CW-1:0] sel;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!found && elig[idx[CW-1:0]]) begin
            found = 1'b1;
            sel   = idx[CW-1:0];
         end
      end
      poll_vld = found;
      poll_ch  = sel;
      if (!found)
         rr_d = rr_q;
      else if (sel == CW'(NUM_CHANNELS - 1))
         rr_d = '0;
      else
         rr_d = sel + 1'b1;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= '0;
      else        rr_q <= rr_d;
   end

   assign all_idle = ~|busy;

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [BW-1:0]         bo_q, bo_d;
      logic [BW-1:0]         dly_q, dly_d;
      logic [PW-1:0]         wr_q, wr_d;
      logic [PW-1:0]         rd_q, rd_d;
      logic [LW-1:0]         cnt_q, cnt_d;
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      logic                  sel_me;
      logic                  push;
      int                    next_dly;

      assign sel_me   = poll_vld && (poll_ch == CW'(gi));
      assign push     = sel_me && poll_hit;
      assign pop[gi]  = (cnt_q != '0) && data_rdy[gi];
      // A full FIFO stays eligible when its head leaves this same cycle.
      assign elig[gi] = rst_n && started_q && (bo_q == '0) &&
                        ((cnt_q < LW'(DEPTH)) || pop[gi]);
      assign busy[gi] = (cnt_q != '0) || (started_q && (bo_q == '0));

      assign data_vld[gi]                          = (cnt_q != '0);
      assign data[gi*DATA_WIDTH +: DATA_WIDTH]     = (cnt_q != '0) ? mem_q[rd_q] : '0;
      assign fill_level[gi*LW +: LW]               = cnt_q;

      // Backoff and FIFO pointer next-state.
      always_comb begin
         next_dly = 2 * int'(dly_q);
         if (next_dly < DELAY_INACTIVE_MIN) next_dly = DELAY_INACTIVE_MIN;
         if (next_dly > DELAY_INACTIVE_MAX) next_dly = DELAY_INACTIVE_MAX;
         bo_d  = bo_q;
         dly_d = dly_q;
         if (sel_me) begin
            if (poll_hit) begin
               bo_d  = BW'(DELAY_ACTIVE);
               dly_d = '0;
            end else begin
               bo_d  = BW'(next_dly);
               dly_d = BW'(next_dly);
            end
         end else if (bo_q != '0) begin
            bo_d = bo_q - 1'b1;
         end
         wr_d  = push    ? wr_q + 1'b1 : wr_q;
         rd_d  = pop[gi] ? rd_q + 1'b1 : rd_q;
         cnt_d = cnt_q;
         if (push && !pop[gi])      cnt_d = cnt_q + 1'b1;
         else if (!push && pop[gi]) cnt_d = cnt_q - 1'b1;
      end

      // Channel control state; reset discards anything still buffered.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            bo_q  <= '0;
            dly_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            bo_q  <= bo_d;
            dly_q <= dly_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      // Payload storage; occupancy alone decides what is valid.
      always_ff @(posedge clk) begin
         if (push) mem_q[wr_q] <= poll_data;
      end
   end

endmodule

// File: tb/tb_multisim_server_pull_multi.sv
// Randomized bench for the multi-channel pull server.
// The bench plays every channel's server.
// A queue-based reference model predicts polls, FIFO contents, occupancy and idleness.
module tb_multisim_server_pull_multi;

   localparam int N     = 4;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int DA    = 0;
   localparam int DMIN  = 1;
   localparam int DMAX  = 8;
   localparam int CW    = 2;
   localparam int LW    = 3;

   logic            clk;
   logic            rst_n;
   logic            server_name_set;
   logic            start_vld;
   logic [CW-1:0]   start_ch;
   logic            poll_vld;
   logic [CW-1:0]   poll_ch;
   logic            poll_hit;
   logic [DW-1:0]   poll_data;
   logic [N-1:0]    data_rdy;
   logic [N-1:0]    data_vld;
   logic [N*DW-1:0] data;
   logic [N*LW-1:0] fill_level;
   logic            all_idle;

   logic [N-1:0]    srv_avail;
   logic [55:0]     seq [N];

   int checks;
   int failures;
   int start_pulses;

   // Reference model state.
   logic [63:0] q [N][$];
   int          wait_c [N];
   int          dly [N];
   int          rr;
   bit          started_m;
   int          start_idx_m;

   multisim_server_pull_multi #(
      .NUM_CHANNELS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .DELAY_ACTIVE(DA),
      .DELAY_INACTIVE_MIN(DMIN), .DELAY_INACTIVE_MAX(DMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .server_name_set(server_name_set),
      .start_vld(start_vld), .start_ch(start_ch),
      .poll_vld(poll_vld), .poll_ch(poll_ch), .poll_hit(poll_hit), .poll_data(poll_data),
      .data_rdy(data_rdy), .data_vld(data_vld), .data(data),
      .fill_level(fill_level), .all_idle(all_idle)
   );

   always #5 clk = ~clk;

   // Server side: answers a poll in the same cycle, like a function return.
   always_comb begin
      poll_hit  = srv_avail[poll_ch];
      poll_data = {8'(poll_ch), seq[poll_ch]};
   end

   always @(posedge clk) if (start_vld) start_pulses++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit idle_m;
      idle_m = 1'b1;
      for (int i = 0; i < N; i++) begin
         check("data_vld", data_vld[i], q[i].size() > 0);
         check("fill_level", fill_level[i*LW +: LW], q[i].size());
         if (q[i].size() > 0) check("data", data[i*DW +: DW], q[i][0]);
         else                 check("data_zero", data[i*DW +: DW], 64'd0);
         if (q[i].size() > 0 || (started_m && wait_c[i] == 0)) idle_m = 1'b0;
      end
      check("all_idle", all_idle, idle_m);
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         wait_c[i] = 0;
         dly[i]    = 0;
      end
      rr = 0;
   endtask

   // One clock: predict and check this edge's start/poll, then advance the model.
   task automatic step();
      bit          popm [N];
      bit          found;
      bit          hit;
      bit          exp_start;
      int          sel;
      int          idx;
      int          nd;
      logic [63:0] val;
      exp_start = server_name_set && !started_m;
      check("start_vld", start_vld, exp_start);
      if (exp_start) check("start_ch", start_ch, start_idx_m);
      found = 1'b0;
      sel   = 0;
      for (int i = 0; i < N; i++) popm[i] = (q[i].size() > 0) && data_rdy[i];
      for (int k = 0; k < N; k++) begin
         idx = (rr + k) % N;
         if (!found && started_m && wait_c[idx] == 0 &&
             (q[idx].size() < DEPTH || popm[idx])) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      check("poll_vld", poll_vld, found);
      if (found) check("poll_ch", poll_ch, sel);
      hit = found && srv_avail[sel];
      val = {8'(sel), seq[sel]};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (popm[i]) begin
            $display("pop ch=%0d data=%h", i, q[i][0]);
            void'(q[i].pop_front());
         end
      end
      for (int i = 0; i < N; i++) begin
         if (found && i == sel) begin
            if (hit) begin
               q[i].push_back(val);
               seq[i]    = seq[i] + 1;
               wait_c[i] = DA;
               dly[i]    = 0;
            end else begin
               nd = 2 * dly[i];
               if (nd < DMIN) nd = DMIN;
               if (nd > DMAX) nd = DMAX;
               dly[i]    = nd;
               wait_c[i] = nd;
            end
         end else if (wait_c[i] > 0) begin
            wait_c[i]--;
         end
      end
      if (found) rr = (sel + 1) % N;
      if (exp_start) begin
         start_idx_m++;
         if (start_idx_m == N) begin
            started_m   = 1'b1;
            start_idx_m = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input int prdy, input int pavail, input logic [N-1:0] hold_low);
      for (int c = 0; c < n; c++) begin
         check_outputs();
         for (int i = 0; i < N; i++) begin
            data_rdy[i]  = ($urandom_range(99) < prdy) && !hold_low[i];
            srv_avail[i] = ($urandom_range(99) < pavail);
         end
         #1;
         step();
      end
   endtask

   initial begin
      clk             = 1'b0;
      rst_n           = 1'b0;
      server_name_set = 1'b0;
      data_rdy        = '0;
      srv_avail       = '0;
      checks          = 0;
      failures        = 0;
      start_pulses    = 0;
      started_m       = 1'b0;
      start_idx_m     = 0;
      for (int i = 0; i < N; i++) seq[i] = 56'd0;
      model_clear();

      repeat (3) @(negedge clk);
      check_outputs();
      check("poll_in_reset", poll_vld, 1'b0);
      rst_n = 1'b1;

      // No name yet: nothing starts, nothing polls.
      run(4, 100, 100, '0);
      server_name_set = 1'b1;
      // Starts, then steady rotation with every server supplying data.
      run(40, 100, 100, '0);
      // Backpressure on ch0 fills its FIFO and stops its polls.
      run(30, 100, 100, 4'b0001);
      check("fill0_full", fill_level[0 +: LW], DEPTH);
      // Drain ch0.
      run(20, 100, 100, '0);
      // Empty servers drive the backoff up to saturation.
      run(80, 100, 0, '0);
      // Data returns.
      run(30, 100, 100, '0);
      // Full FIFOs with concurrent push/pop.
      run(80, 50, 100, '0);
      run(100, 60, 50, '0);

      // Asynchronous reset with data buffered.
      run(6, 0, 100, '0);
      check_outputs();
      #2 rst_n = 1'b0;
      #1;
      check("vld_async_rst", data_vld, '0);
      check("fill_async_rst", fill_level, '0);
      check("poll_async_rst", poll_vld, 1'b0);
      model_clear();
      @(negedge clk);
      check_outputs();
      check("poll_held_rst", poll_vld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run(150, 70, 70, '0);
      check("start_once", start_pulses, N);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
